// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative RV32M multiplier.
package mul_pkg;
  localparam int XLEN     = 32;
  localparam int MUL_ITER = 32;

  typedef enum logic [1:0] {MUL, MULH, MULHSU, MULHU} mul_op_e;
  typedef enum logic [2:0] {IDLE, MULT, NEG_LO, NEG_HI, DONE} mul_state_e;
endpackage

// File: rtl/full_adder_32bit.sv
// 32-bit ripple-style full adder with carry in/out.
module full_adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'b0, ci};
endmodule

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU. One adder is
// time-shared between the 32 accumulate steps and the two-word negation.
module seq_mul_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  import mul_pkg::*;

  mul_state_e      state, nxt;
  mul_op_e         op_in, op_q;
  logic [XLEN-1:0] hi, lo, mcand, res_q, sel;
  logic [4:0]      cnt;
  logic            neg_q, nc;
  logic            a_s, b_s, neg_in;
  logic [XLEN-1:0] mag1, mag2;

  logic [XLEN-1:0] add_a, add_b, add_s;
  logic            add_ci, add_co;

  // Signedness decode and magnitude conversion at capture; 0x80000000 stays
  // 0x80000000 and is then treated as unsigned.
  assign op_in  = mul_op_e'(i_op);
  assign a_s    = (op_in == MULH) || (op_in == MULHSU);
  assign b_s    = (op_in == MULH);
  assign neg_in = (a_s & i_rs1[XLEN-1]) ^ (b_s & i_rs2[XLEN-1]);
  assign mag1   = (a_s && i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
  assign mag2   = (b_s && i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;

  full_adder_32bit u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    unique case (state)
      MULT: begin
        add_a = hi;
        add_b = lo[0] ? mcand : '0;
      end
      NEG_LO: begin
        add_a  = ~lo;
        add_ci = 1'b1;
      end
      NEG_HI: begin
        add_a  = ~hi;
        add_ci = nc;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (i_start) nxt = MULT;
      MULT:    if (cnt == 5'(MUL_ITER - 1)) nxt = neg_q ? NEG_LO : DONE;
      NEG_LO:  nxt = NEG_HI;
      NEG_HI:  nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      op_q  <= MUL;
      neg_q <= 1'b0;
      nc    <= 1'b0;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      res_q <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (i_start) begin
          op_q  <= op_in;
          neg_q <= neg_in;
          mcand <= mag1;
          hi    <= '0;
          lo    <= mag2;
          cnt   <= '0;
        end
        MULT: begin
          // Product shifts right one bit per step; multiplier bits drain out of lo.
          hi  <= {add_co, add_s[XLEN-1:1]};
          lo  <= {add_s[0], lo[XLEN-1:1]};
          cnt <= cnt + 5'd1;
        end
        NEG_LO: begin
          lo <= add_s;
          nc <= add_co;
        end
        NEG_HI: hi <= add_s;
        DONE:   res_q <= sel;
        default: ;
      endcase
    end
  end

  assign sel      = (op_q == MUL) ? lo : hi;
  assign o_busy   = (state != IDLE);
  assign o_done   = (state == DONE);
  assign o_result = o_done ? sel : res_q;
endmodule

// File: tb/tb_seq_mul_unit.sv
// Randomized self-checking bench for seq_mul_unit against a 64-bit arithmetic model.
module tb_seq_mul_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  seq_mul_unit dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (start),
    .i_op     (op),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, za, sb, zb, p;
    sa = {{32{a[31]}}, a};
    za = {32'b0, a};
    sb = {{32{b[31]}}, b};
    zb = {32'b0, b};
    case (o)
      2'd0:    begin p = za * zb; return p[31:0];  end
      2'd1:    begin p = sa * sb; return p[63:32]; end
      2'd2:    begin p = sa * zb; return p[63:32]; end
      default: begin p = za * zb; return p[63:32]; end
    endcase
  endfunction

  // Cycle (counted from the start cycle) in which done is expected.
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic neg;
    case (o)
      2'd1:    neg = a[31] ^ b[31];
      2'd2:    neg = a[31];
      default: neg = 1'b0;
    endcase
    return neg ? 35 : 33;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one request; intf>0 pulses a competing start with 3x3 in that cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int intf, input string tag);
    logic [31:0] exp, res;
    int lat, done_cyc, pulses, busy_cnt;
    exp = ref_res(o, a, b);
    lat = ref_lat(o, a, b);
    done_cyc = 0; pulses = 0; busy_cnt = 0; res = '0;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (k <= lat && busy) busy_cnt++;
      if (k == lat + 1) chk({tag, " busy_after"}, 64'(busy), 64'(0));
      if (k == lat + 2) chk({tag, " held"}, 64'(result), 64'(exp));
      if (done) begin
        pulses++;
        if (done_cyc == 0) begin done_cyc = k; res = result; end
      end
      if (k == intf) begin
        start = 1'b1; rs1 = 32'd3; rs2 = 32'd3; op = 2'($urandom);
      end else begin
        start = 1'b0; rs1 = $urandom; rs2 = $urandom; op = 2'($urandom);
      end
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(done_cyc), 64'(lat));
    chk({tag, " result"},  64'(res),      64'(exp));
    chk({tag, " busy"},    64'(busy_cnt), 64'(lat));
    chk({tag, " pulses"},  64'(pulses),   64'(1));
  endtask

  initial begin
    int pulses;
    rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(negedge clk);
    chk("rst busy",   64'(busy),   64'(0));
    chk("rst done",   64'(done),   64'(0));
    chk("rst result", 64'(result), 64'(0));
    rst = 1'b0;

    run_op(2'd0, 32'd7,          32'd6,          0, "mul 7x6");
    run_op(2'd0, 32'hFFFF_FFFD,  32'd5,          0, "mul -3x5");
    run_op(2'd3, 32'hFFFF_FFFD,  32'd5,          0, "mulhu -3x5");
    run_op(2'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, "mulh -1x-1");
    run_op(2'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, "mulhu ff x ff");
    run_op(2'd2, 32'hFFFF_FFFF,  32'd2,          0, "mulhsu -1x2");
    run_op(2'd1, 32'h8000_0000,  32'h8000_0000,  0, "mulh min x min");
    run_op(2'd3, 32'h0001_0000,  32'h0001_0000,  5, "mulhu ignore start");

    // Abort mid-operation with reset, asserted together with a start request.
    @(negedge clk);
    start = 1'b1; op = 2'd0; rs1 = 32'd9; rs2 = 32'd9;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("abort busy",   64'(busy),   64'(0));
    chk("abort done",   64'(done),   64'(0));
    chk("abort result", 64'(result), 64'(0));
    rst = 1'b0; start = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort no done", 64'(pulses), 64'(0));
    chk("abort idle",    64'(busy),   64'(0));
    run_op(2'd0, 32'd9, 32'd9, 0, "mul 9x9 after abort");

    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      o = 2'($urandom);
      run_op(o, pick(), pick(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Iterative shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions.
- Instantiates the existing full_adder_32bit as its only datapath adder and consumes its sum and carry every iteration.
- Sits beside the ALU in the execute stage. The control unit stalls the PC while o_busy is high.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported because the adder is fixed at 32 bits.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge
- i_reset  input  1  synchronous, active-high reset
- i_start  input  1  request; sampled only in IDLE
- i_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- i_rs1  input  32  multiplicand operand
- i_rs2  input  32  multiplier operand
- o_busy  output  1  high in every non-IDLE state
- o_done  output  1  one-cycle pulse; o_result valid in that cycle
- o_result  output  32  low word for MUL, high word otherwise; held until next completion

Behaviour:
- Reset (i_reset high at an edge):
  - state IDLE; o_busy=0, o_done=0, o_result=0; counter and product registers cleared.
  - Reset mid-operation aborts: no o_done pulse, o_result keeps 0.
- States: IDLE, MULT, NEG_LO, NEG_HI, DONE.
- IDLE + i_start=1, start cycle C0:
  - Capture op.
  - a_s = rs1 signed for MULH/MULHSU; b_s = rs2 signed for MULH only.
  - neg = (a_s & rs1[31]) ^ (b_s & rs2[31]).
  - mcand = |rs1| if a_s else rs1; mplr = |rs2| if b_s else rs2. Two's-complement magnitude; 0x80000000 maps to 0x80000000 treated as unsigned.
  - Load hi=0, lo=mplr, cnt=0. Go to MULT.
- IDLE + i_start=0: stay in IDLE.
- MULT, one iteration per cycle, C1..C32:
  - Adder inputs: a=hi, b=(lo[0] ? mcand : 0), ci=0.
  - Update: hi <= {co, s[31:1]}; lo <= {s[0], lo[31:1]}; cnt++.
  - After the 32nd iteration (cnt==31 at the edge), go to NEG_LO if neg else DONE.
- MUL (op 00) always runs unsigned with neg=0. The low word is identical for all signedness.
- NEG_LO:
  - Adder inputs: a=~lo, b=0, ci=1. lo <= s; the carry is registered as nc.
  - Go to NEG_HI.
- NEG_HI:
  - Adder inputs: a=~hi, b=0, ci=nc. hi <= s.
  - Go to DONE.
- DONE:
  - o_done=1; o_result driven from registered selection (op==MUL ? lo : hi) and latched into the output register.
  - Next state IDLE unconditionally.
- Latency: o_done is high in cycle C33 without negation, C35 with negation. Next start is accepted no earlier than C34/C36.
- i_start while o_busy=1 or in DONE: ignored; no operand capture.
- Operand changes after C0 have no effect.
- Simultaneous i_reset and i_start: reset wins.
- The adder is time-shared: its inputs are muxed by state and held at zero in IDLE/DONE.

Decomposition:
- Shared package mul_pkg:
  - typedef enum logic [1:0] mul_op_e {MUL, MULH, MULHSU, MULHU}
  - typedef enum mul_state_e {IDLE, MULT, NEG_LO, NEG_HI, DONE}
  - localparam XLEN=32, MUL_ITER=32
- Sub-module: exactly one instance of full_adder_32bit. No new sub-module.
- Magnitude conversion at capture is inline logic.

Test Plan:
- MUL: rs1=7, rs2=6, start at C0 -> o_done only at C33, o_result=0x0000002A, o_busy high C1..C33.
- MUL: rs1=0xFFFFFFFD, rs2=5 -> o_result=0xFFFFFFF1 at C33. MULHU with the same operands -> 0x00000004.
- MULH: 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 at C33 (no negation). MULHU with the same operands -> 0xFFFFFFFE.
- MULHSU: 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF at C35 (negation path). MULH: 0x80000000 x 0x80000000 -> 0x40000000 at C33.
- Start MULHU 0x10000 x 0x10000, then pulse i_start with rs1=rs2=3 at C5 -> second request ignored; o_result=0x00000001 at C33; no second o_done.
- Start MUL 9x9, assert i_reset at C10 -> o_busy=0 from C11, no o_done, o_result=0. A fresh MUL 9x9 then yields 0x51 33 cycles after its start.
